// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX byte port among NREQ requesters.
// Grant held until req_last; a mid-packet gap of TIMEOUT FETCH cycles revokes it.
module uart_tx_arbiter #(
  parameter int          NREQ    = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ready_i,
  output logic [NREQ-1:0]   grant_o,
  output logic              timeout_err_o
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [15:0]       gap_q, gap_d;
  logic              last_q, last_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              terr_q, terr_d;

  logic              found;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     nxt_ptr;

  // First requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid_i[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign nxt_ptr = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    grant_d     = grant_q;
    gap_d       = gap_q;
    last_d      = last_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    terr_d      = 1'b0;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        gap_d   = '0;
        if (found) begin
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          idx_d   = sel;
          state_d = FETCH;
        end
      end
      FETCH: begin
        req_ready_o = grant_q;
        if (req_valid_i[idx_q]) begin
          tx_data_d  = req_data_i[8*idx_q +: 8];
          last_d     = req_last_i[idx_q];
          tx_valid_d = 1'b1;
          gap_d      = '0;
          state_d    = SEND;
        end else begin
          gap_d = gap_q + 16'd1;
          if ((TIMEOUT != 16'd0) && (gap_q == TIMEOUT - 16'd1)) begin
            terr_d  = 1'b1;
            grant_d = '0;
            ptr_d   = nxt_ptr;
            state_d = IDLE;
          end
        end
      end
      SEND: begin
        // No gap counting here: a stalled serializer must not cost the owner its grant.
        if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          if (last_q) begin
            grant_d = '0;
            ptr_d   = nxt_ptr;
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      grant_q    <= '0;
      gap_q      <= '0;
      last_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      grant_q    <= grant_d;
      gap_q      <= gap_d;
      last_q     <= last_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      terr_q     <= terr_d;
    end
  end

  assign tx_valid_o    = tx_valid_q;
  assign tx_data_o     = tx_data_q;
  assign grant_o       = grant_q;
  assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte streams, expected-order queue checked on TX accept.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [3:0]  grant;
  logic        timeout_err;

  logic [8:0]  strm [NREQ][$];
  logic [10:0] sb [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(16'd16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .grant_o(grant), .timeout_err_o(timeout_err)
  );

  // Requester models: present the head of each stream, pop it once consumed.
  initial begin
    logic [3:0] fire;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready & {4{rst_n}};
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (fire[i] && strm[i].size() > 0) void'(strm[i].pop_front());
        req_valid[i] = (strm[i].size() > 0);
        if (strm[i].size() > 0) begin
          req_data[8*i +: 8] = strm[i][0][7:0];
          req_last[i]        = strm[i][0][8];
        end else begin
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // TX monitor: order/owner against the scoreboard, and hold-while-stalled.
  initial begin
    logic pv, pr, prst;
    logic [7:0] pd;
    logic [10:0] e;
    logic [3:0] eg;
    pv = 1'b0; pr = 1'b0; prst = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && prst && pv && !pr) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== pd) begin
          errors++;
          $display("FAIL hold: tx_valid=%b tx_data=%h, required 1/%h", tx_valid, tx_data, pd);
        end
      end
      if (rst_n && tx_valid && tx_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: tx_data=%h grant=%b, none expected", tx_data, grant);
        end else begin
          e  = sb.pop_front();
          eg = 4'b0001 << e[10:8];
          if (tx_data !== e[7:0] || grant !== eg) begin
            errors++;
            $display("FAIL byte_order: got data=%h grant=%b, required data=%h grant=%b",
                     tx_data, grant, e[7:0], eg);
          end
        end
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data; prst = rst_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input int id, input logic [7:0] d, input logic last);
    strm[id].push_back({last, d});
  endtask

  task automatic exp_b(input logic [2:0] id, input logic [7:0] d);
    sb.push_back({id, d});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) strm[i].delete();
    sb.delete();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_size(input string name, input int n);
    for (int c = 0; c < 500 && sb.size() != n; c++) tick();
    checks++;
    if (sb.size() != n) begin
      errors++;
      $display("FAIL %s: scoreboard depth %0d, required %0d", name, sb.size(), n);
    end
  endtask

  task automatic wait_vld(input string name);
    for (int c = 0; c < 100 && tx_valid !== 1'b1; c++) tick();
    chk(name, {31'd0, tx_valid}, 32'd1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    put(0, 8'h41, 1'b0); put(0, 8'h42, 1'b0); put(0, 8'h43, 1'b1);
    exp_b(0, 8'h41); exp_b(0, 8'h42); exp_b(0, 8'h43);
    tick();
    chk("single_req_seen_grant", {28'd0, grant}, 32'd0);
    tick();
    chk("single_grant", {28'd0, grant}, 32'h1);
    chk("single_req_ready", {28'd0, req_ready}, 32'h1);
    tick();
    chk("single_first_vld", {31'd0, tx_valid}, 32'd1);
    chk("single_first_dat", {24'd0, tx_data}, 32'h41);
    chk("single_send_ready", {28'd0, req_ready}, 32'd0);
    tick(); tick();
    chk("single_second_dat", {24'd0, tx_data}, 32'h42);
    tick(); tick();
    chk("single_third_dat", {24'd0, tx_data}, 32'h43);
    chk("single_grant_held", {28'd0, grant}, 32'h1);
    tick();
    chk("single_grant_drop", {28'd0, grant}, 32'd0);
    chk("single_vld_drop", {31'd0, tx_valid}, 32'd0);
    wait_size("single_drain", 0);
  endtask

  task automatic test_fairness();
    do_reset();
    put(1, 8'hA1, 1'b0); put(1, 8'hA2, 1'b1);
    put(3, 8'hB1, 1'b0); put(3, 8'hB2, 1'b1);
    exp_b(1, 8'hA1); exp_b(1, 8'hA2); exp_b(3, 8'hB1); exp_b(3, 8'hB2);
    wait_size("fair_drain", 0);
    // Pointer should have wrapped to 0, so 0 beats 1 here.
    put(1, 8'hC1, 1'b1); put(0, 8'hC0, 1'b1);
    exp_b(0, 8'hC0); exp_b(1, 8'hC1);
    wait_size("fair_wrap_drain", 0);
  endtask

  task automatic test_no_interleave();
    do_reset();
    put(0, 8'h50, 1'b0); put(0, 8'h51, 1'b0); put(0, 8'h52, 1'b1);
    exp_b(0, 8'h50); exp_b(0, 8'h51); exp_b(0, 8'h52);
    wait_size("nointl_first", 2);
    put(2, 8'h60, 1'b0); put(2, 8'h61, 1'b1);
    exp_b(2, 8'h60); exp_b(2, 8'h61);
    wait_size("nointl_pkt0_done", 2);
    chk("nointl_gap_grant", {28'd0, grant}, 32'd0);
    tick();
    chk("nointl_next_grant", {28'd0, grant}, 32'h4);
    wait_size("nointl_drain", 0);
  endtask

  task automatic test_backpressure();
    do_reset();
    tx_ready = 1'b0;
    put(0, 8'h77, 1'b1);
    exp_b(0, 8'h77);
    wait_vld("bp_vld");
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("bp_vld_hold", {31'd0, tx_valid}, 32'd1);
      chk("bp_dat_hold", {24'd0, tx_data}, 32'h77);
      chk("bp_no_timeout", {31'd0, timeout_err}, 32'd0);
    end
    tx_ready = 1'b1;
    wait_size("bp_drain", 0);
    tick();
    chk("bp_grant_after", {28'd0, grant}, 32'd0);
  endtask

  task automatic test_timeout();
    do_reset();
    put(0, 8'h80, 1'b0);
    put(1, 8'h90, 1'b1);
    exp_b(0, 8'h80); exp_b(1, 8'h90);
    wait_size("to_first", 1);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("to_early", {27'd0, timeout_err, grant}, 32'h1);
    end
    tick();
    chk("to_pulse", {31'd0, timeout_err}, 32'd1);
    chk("to_grant_cleared", {28'd0, grant}, 32'd0);
    tick();
    chk("to_pulse_end", {31'd0, timeout_err}, 32'd0);
    chk("to_next_grant", {28'd0, grant}, 32'h2);
    wait_size("to_drain", 0);
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    tx_ready = 1'b0;
    put(0, 8'hD0, 1'b0); put(0, 8'hD1, 1'b1);
    wait_vld("rms_vld");
    rst_n = 1'b0;
    tick();
    chk("rms_grant", {28'd0, grant}, 32'd0);
    chk("rms_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rms_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rms_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rms_req_ready", {28'd0, req_ready}, 32'd0);
    for (int i = 0; i < NREQ; i++) strm[i].delete();
    sb.delete();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    put(2, 8'hE2, 1'b1); put(0, 8'hE0, 1'b1);
    exp_b(0, 8'hE0); exp_b(2, 8'hE2);
    wait_size("rms_drain", 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_no_interleave();
    test_backpressure();
    test_timeout();
    test_reset_mid_send();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares one UART transmitter byte port between NREQ independent byte-stream requesters (debug console, status reporter, command responder, ...). A grant is held for a whole packet, delimited by `req_last`, so bytes from different requesters never interleave on the line. A gap timeout releases a requester that stalls mid-packet. Sits between the requester logic and the UART TX serializer, in the same clock domain.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `TIMEOUT`, 16'd50000: maximum idle cycles in FETCH while a packet is open; 0 disables the timeout.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NREQ: requester i has a byte on its slice of `req_data`.
- `req_data` in 8*NREQ: byte of requester i at bits [8i+7:8i].
- `req_last` in NREQ: the offered byte is the last byte of requester i's packet.
- `req_ready` out NREQ: combinational; byte of requester i is consumed this cycle when `req_valid[i] && req_ready[i]`.
- `tx_valid` out 1: registered; byte available to the UART TX.
- `tx_data` out 8: registered; byte to transmit.
- `tx_ready` in 1: UART TX accepts `tx_data` when `tx_valid && tx_ready`.
- `grant` out NREQ: registered, one-hot or zero; current packet owner.
- `timeout_err` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, FETCH, SEND.
- IDLE: `grant`=0. If any `req_valid` is set, select the first set bit searching upward from `ptr` with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...). Load the one-hot `grant` and go to FETCH. Clear `gap_cnt`.
- FETCH: `req_ready[g]` = 1 for the granted index only; all other `req_ready` bits are 0 in every state.
  - If `req_valid[g]`: capture the data into `tx_data` and `req_last[g]` into `last_buf`, set `tx_valid`, clear `gap_cnt`, go to SEND.
  - Otherwise increment `gap_cnt`. If `TIMEOUT`≠0 and `gap_cnt` reaches `TIMEOUT`-1 in this cycle: pulse `timeout_err`, clear `grant`, set `ptr`=(g+1) mod NREQ, go to IDLE.
- SEND: hold `tx_valid` and `tx_data` stable until `tx_ready`. On accept, clear `tx_valid`.
  - If `last_buf`: clear `grant`, set `ptr`=(g+1) mod NREQ, go to IDLE.
  - Otherwise return to FETCH, keeping the grant.
  - The timeout does not run in SEND; a stalled TX never revokes a grant.
- `ptr` is $clog2(NREQ) bits and wraps modulo NREQ. For non-power-of-two NREQ, g+1 == NREQ wraps to 0.
- `req_valid` on non-granted requesters during a packet is ignored; those requests stay pending.
- A single-byte packet (`req_last` with the first byte) is legal.
- Reset (`rst_n`=0 on a rising edge, in any state, including mid-packet or mid-SEND):
  - state=IDLE, `ptr`=0, `gap_cnt`=0, `last_buf`=0.
  - Outputs: `grant`=0, `tx_valid`=0, `tx_data`=8'h00, `timeout_err`=0.
  - A buffered byte is discarded and not sent.

## Timing
- Request to grant: `req_valid` high at edge N in IDLE gives `grant` valid after edge N+1.
- In FETCH, `req_ready` is high in the same cycle as `grant`. The byte is consumed at edge N+2 and `tx_valid` is high after edge N+2.
- Byte accepted by TX at edge M: next `req_ready` after M+0 (in FETCH). Peak rate is one byte per 2 cycles with `tx_ready` tied high.
- End of packet to next grant: 2 cycles (SEND to IDLE, then IDLE to FETCH). `grant` is 0 for exactly one cycle between packets.
- Timeout fires after exactly `TIMEOUT` consecutive FETCH cycles without `req_valid[g]`. `timeout_err` is high during the first IDLE cycle, and that cycle may also arbitrate.
- `tx_valid` never drops without acceptance. `tx_data` never changes while `tx_valid`=1 and `tx_ready`=0.

## Test plan
- Single packet: requester 0 sends 8'h41, 8'h42, 8'h43 (last on 8'h43), `tx_ready`=1 -> `tx_data` sequence 41, 42, 43; `grant`=4'b0001 throughout; `grant` drops 1 cycle after the 43 accept.
- Fairness: requesters 1 and 3 both hold 2-byte packets from reset -> requester 1 is served fully, then 3; `ptr` ends at 0. Requester 1 requests again immediately -> served before any re-service of 3 only if 3 is idle.
- No interleave: requester 2 asserts `req_valid` mid-packet of requester 0 -> zero bytes from 2 appear before 0's last byte; 2 is granted next.
- Backpressure: `tx_ready`=0 for 100 cycles with a byte in SEND -> `tx_valid` and `tx_data` stable, no `timeout_err`, with `TIMEOUT`=16.
- Timeout: `TIMEOUT`=16, requester 0 drops `req_valid` after byte 1 of a 3-byte packet -> `timeout_err` pulses exactly 16 FETCH cycles later; `grant`=0; requester 1 is granted next if pending.
- Reset mid-SEND: `rst_n` low for 1 cycle while `tx_valid`=1 -> next cycle all outputs are at reset values; the held byte is never accepted; arbitration restarts from requester 0.
